// File: rtl/ram_responder_if.sv
// Request/response bus for ram_responder.
// Master drives the request side, slave returns data, ack, busy and err.
interface ram_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        output req_i,
        output we_i,
        output addr_i,
        output data_i,
        input  data_o,
        input  ack_o,
        input  busy_o,
        input  err_o
    );

    modport slave (
        input  req_i,
        input  we_i,
        input  addr_i,
        input  data_i,
        output data_o,
        output ack_o,
        output busy_o,
        output err_o
    );
endinterface

// File: rtl/ram_responder.sv
// Single-port word RAM behind a fixed-latency request/ack handshake.
// One request is accepted in IDLE, counted down in BUSY, answered with a
// one-cycle ack, then RESP returns to IDLE.
// Optional feature: define RAM_RESPONDER_BOUNDS_CHECK_EN to flag requests whose
// address lies beyond the array (no write, data 0, err with ack). Without it
// the upper address bits are ignored and err_o stays 0.
module ram_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic           clk,
    input  logic           reset,
    ram_responder_if.slave bus
);

    localparam int unsigned Words = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  we_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic                  oor_q;

    logic [31:0]           data_q;
    logic                  ack_q;
    logic                  busy_q;
    logic                  err_q;

    logic [31:0]           mem [Words];

    logic                  oor_in;
    logic                  fire;
    logic                  commit_we;

`ifdef RAM_RESPONDER_BOUNDS_CHECK_EN
    // Any set bit above the word index makes the request out of range.
    assign oor_in = (bus.addr_i >> (DEPTH_LOG2 + 2)) != 32'd0;

    logic unused_addr;
    assign unused_addr = ^bus.addr_i[1:0];
`else
    // Upper bits are dropped so the address wraps modulo the array size.
    assign oor_in = 1'b0;

    logic unused_addr;
    assign unused_addr = ^{bus.addr_i[1:0], bus.addr_i[31:DEPTH_LOG2+2]};
`endif

    // Last BUSY cycle: the response is produced and any write committed.
    assign fire      = (state_q == StBusy) && (cnt_q == 4'd0);
    assign commit_we = fire && we_q && !oor_q;

    // Storage array; deliberately outside the reset domain so reset keeps
    // contents, while a reset in BUSY still drops the pending write because
    // the state register is forced out of BUSY.
    always_ff @(posedge clk) begin
        if (commit_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            oor_q   <= 1'b0;
            data_q  <= 32'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_i) begin
                        we_q    <= bus.we_i;
                        idx_q   <= bus.addr_i[DEPTH_LOG2+1:2];
                        wdata_q <= bus.data_i;
                        oor_q   <= oor_in;
                        cnt_q   <= 4'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        ack_q   <= 1'b1;
                        err_q   <= oor_q;
                        state_q <= StResp;
                        if (oor_q) begin
                            data_q <= 32'd0;
                        end else if (we_q) begin
                            data_q <= wdata_q;
                        end else begin
                            data_q <= mem[idx_q];
                        end
                    end
                end
                StResp: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.data_o = data_q;
    assign bus.ack_o  = ack_q;
    assign bus.busy_o = busy_q;
    assign bus.err_o  = err_q;

endmodule
